// File: rtl/radiant_event_hdr_ctrl.sv
// RADIANT event/timing control core: PPS-disciplined second/clock/event counters
// and a DEPTH-deep event header buffer drained by software over Wishbone.
module radiant_event_hdr_ctrl #(
  parameter int DEPTH     = 16,
  parameter int NUM_INFO  = 1,
  parameter int CNT_WIDTH = 48
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [8:0]             wb_adr_i,
  input  logic [31:0]            wb_dat_i,
  input  logic [3:0]             wb_sel_i,
  output logic [31:0]            wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   wb_rty_o,
  input  logic                   pps_i,
  input  logic                   event_i,
  input  logic [32*NUM_INFO-1:0] event_info_i,
  output logic                   event_ready_o,
  output logic                   event_full_o
);

  localparam int HDR_WORDS = 7 + NUM_INFO;
  localparam int PW        = $clog2(DEPTH);
  localparam int AW        = PW + 1;
  localparam logic [31:0]          MAGIC   = 32'h5244_4531;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [6:0]           LAST_WORD_ADR = 7'(64 + HDR_WORDS - 1);

  // Counters and timing snapshots
  logic [CNT_WIDTH-1:0] r_sec;
  logic [CNT_WIDTH-1:0] r_sysclk;
  logic [CNT_WIDTH-1:0] r_evcount;
  logic [31:0]          r_last_pps;
  logic [31:0]          r_lastlast_pps;
  logic                 r_armed;
  logic                 r_ref_ev32;
  logic                 r_ref_sec32;
  logic                 r_ref_clk32;

  // Drop accounting
  logic [31:0]          r_drops;
  logic [15:0]          r_hdr_drops;

  // Header buffer
  logic [31:0]          r_mem [DEPTH][HDR_WORDS];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;

  logic                 r_ack;

  logic [6:0]           w_word;
  logic                 w_is_hdr;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_ctrl_wr;
  logic                 w_flush;
  logic                 w_arm;
  logic                 w_drops_clr;
  logic                 w_sync;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;
  logic [AW-1:0]        w_occ;
  logic                 w_empty;
  logic                 w_full;
  logic [31:0]          w_status;
  logic [31:0]          w_hdr [HDR_WORDS];
  logic [31:0]          w_head_word;
  logic                 w_unused;

  // Wishbone handshake: a cycle is requested while cyc & stb are high; ack is
  // registered and held one cycle, and all side effects (flush, arm, clear,
  // pop) happen on that ack cycle, so each access takes exactly two cycles.
  assign wb_ack_o = r_ack & wb_cyc_i;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;

  assign w_word      = wb_adr_i[8:2];
  assign w_is_hdr    = w_word[6];
  assign w_wr        = wb_ack_o & wb_we_i;
  assign w_rd        = wb_ack_o & ~wb_we_i;
  assign w_ctrl_wr   = w_wr & (w_word == 7'd0);
  assign w_flush     = w_ctrl_wr & wb_dat_i[0];
  assign w_arm       = w_ctrl_wr & wb_dat_i[1];
  assign w_drops_clr = w_wr & (w_word == 7'd4);
  assign w_sync      = r_armed & pps_i;

  assign w_occ   = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_occ == AW'(DEPTH));

  // A flush swallows a coincident event without counting it as a drop.
  assign w_push = event_i & ~w_full & ~w_flush;
  assign w_drop = event_i & w_full & ~w_flush;
  assign w_pop  = w_rd & (w_word == LAST_WORD_ADR) & ~w_empty;

  assign event_ready_o = ~w_empty;
  assign event_full_o  = w_full;

  assign w_status = {r_hdr_drops, 12'd0, (r_hdr_drops != 16'd0),
                     r_sysclk[32] ^ r_ref_clk32,
                     r_sec[32] ^ r_ref_sec32,
                     r_evcount[32] ^ r_ref_ev32};

  always_comb begin
    for (int i = 0; i < HDR_WORDS; i++) w_hdr[i] = 32'd0;
    w_hdr[0] = MAGIC;
    w_hdr[1] = r_sec[31:0];
    w_hdr[2] = r_evcount[31:0];
    w_hdr[3] = r_sysclk[31:0];
    w_hdr[4] = w_status;
    w_hdr[5] = r_last_pps;
    w_hdr[6] = r_lastlast_pps;
    for (int j = 0; j < NUM_INFO; j++) w_hdr[7+j] = event_info_i[32*j +: 32];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= wb_cyc_i & wb_stb_i & ~r_ack;
    end
  end

  // Sync takes priority over the normal PPS update; events always capture
  // the values held before this edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sec          <= '0;
      r_sysclk       <= '0;
      r_evcount      <= '0;
      r_last_pps     <= 32'd0;
      r_lastlast_pps <= 32'd0;
      r_armed        <= 1'b0;
      r_ref_ev32     <= 1'b0;
      r_ref_sec32    <= 1'b0;
      r_ref_clk32    <= 1'b0;
    end else if (w_sync) begin
      r_sec          <= '0;
      r_sysclk       <= '0;
      r_evcount      <= '0;
      r_last_pps     <= 32'd0;
      r_lastlast_pps <= 32'd0;
      r_armed        <= 1'b0;
      r_ref_ev32     <= 1'b0;
      r_ref_sec32    <= 1'b0;
      r_ref_clk32    <= 1'b0;
    end else begin
      r_sysclk <= r_sysclk + CNT_ONE;
      if (pps_i) begin
        r_sec          <= r_sec + CNT_ONE;
        r_last_pps     <= r_sysclk[31:0];
        r_lastlast_pps <= r_last_pps;
      end
      if (event_i) begin
        r_evcount <= r_evcount + CNT_ONE;
      end
      if (w_arm) begin
        r_armed <= 1'b1;
      end
      if (w_push) begin
        r_ref_ev32  <= r_evcount[32];
        r_ref_sec32 <= r_sec[32];
        r_ref_clk32 <= r_sysclk[32];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_drops     <= 32'd0;
      r_hdr_drops <= 16'd0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end

      if (w_drops_clr) begin
        r_drops <= 32'd0;
      end else if (w_drop && (r_drops != 32'hFFFF_FFFF)) begin
        r_drops <= r_drops + 32'd1;
      end

      if (w_push) begin
        r_hdr_drops <= 16'd0;
      end else if (w_drop && (r_hdr_drops != 16'hFFFF)) begin
        r_hdr_drops <= r_hdr_drops + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      for (int i = 0; i < HDR_WORDS; i++) r_mem[r_wr_ptr[PW-1:0]][i] <= w_hdr[i];
    end
  end

  always_comb begin
    w_head_word = 32'd0;
    for (int i = 0; i < HDR_WORDS; i++) begin
      if (w_word[5:0] == 6'(i)) w_head_word = r_mem[r_rd_ptr[PW-1:0]][i];
    end
  end

  always_comb begin
    wb_dat_o = 32'd0;
    if (w_is_hdr) begin
      wb_dat_o = w_empty ? 32'hFFFF_FFFF : w_head_word;
    end else begin
      case (w_word[5:0])
        6'd0:    wb_dat_o = {17'd0, 7'(w_occ), 4'd0, w_full, w_empty, r_armed, 1'b0};
        6'd1:    wb_dat_o = r_sec[31:0];
        6'd2:    wb_dat_o = r_last_pps;
        6'd3:    wb_dat_o = r_lastlast_pps;
        6'd4:    wb_dat_o = r_drops;
        6'd5:    wb_dat_o = 32'(r_sec[CNT_WIDTH-1:32]);
        default: wb_dat_o = 32'd0;
      endcase
    end
  end

  assign w_unused = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[31:2], r_evcount, r_sysclk};

endmodule

// File: tb/tb_radiant_event_hdr_ctrl.sv
// Directed bench for radiant_event_hdr_ctrl (DEPTH=4, one info word):
// sync, overflow/drops, PPS/event coincidence, flush, pop/push overlap, rollover.
module tb_radiant_event_hdr_ctrl;
  localparam int DEPTH     = 4;
  localparam int NUM_INFO  = 1;
  localparam int CNT_WIDTH = 48;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [8:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic        pps, event_i;
  logic [31:0] event_info;
  logic        event_ready_o, event_full_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rd;
  logic [31:0] exp_hdr [8];

  always #5 clk = ~clk;

  radiant_event_hdr_ctrl #(
    .DEPTH(DEPTH), .NUM_INFO(NUM_INFO), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(4'hF),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .pps_i(pps), .event_i(event_i), .event_info_i(event_info),
    .event_ready_o(event_ready_o), .event_full_o(event_full_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; ev raises event_i for the ack cycle.
  task automatic wb_xfer(input bit we, input logic [8:0] a, input logic [31:0] wd,
                         input bit ev, output logic [31:0] d);
    int t;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = a; wb_dat = wd;
    @(negedge clk);
    t = 0;
    while (wb_ack_o !== 1'b1 && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (wb_ack_o !== 1'b1) chk("ack_timeout", 32'(wb_ack_o), 32'd1);
    d = wb_dat_o;
    event_i = ev;
    @(negedge clk);
    event_i = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [8:0] a, output logic [31:0] d);
    wb_xfer(1'b0, a, 32'd0, 1'b0, d);
  endtask

  task automatic wb_write(input logic [8:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, wd, 1'b0, dummy);
  endtask

  task automatic send_event(input logic [31:0] info);
    event_i = 1'b1; event_info = info;
    @(negedge clk);
    event_i = 1'b0;
  endtask

  task automatic pps_pulse();
    pps = 1'b1;
    @(negedge clk);
    pps = 1'b0;
  endtask

  task automatic check_header(input string tag);
    logic [31:0] d;
    for (int k = 0; k < 8; k++) begin
      wb_read(9'h100 + 9'(4 * k), d);
      chk($sformatf("%s_w%0d", tag, k), d, exp_hdr[k]);
    end
  endtask

  initial begin
    rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 9'd0; wb_dat = 32'd0;
    pps = 1'b0; event_i = 1'b0; event_info = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_ready", 32'(event_ready_o), 32'd0);
    chk("rst_full", 32'(event_full_o), 32'd0);
    chk("err_rty", 32'({wb_err_o, wb_rty_o}), 32'd0);
    wb_read(9'h000, rd); chk("rst_ctrl", rd, 32'h0000_0004);
    wb_read(9'h010, rd); chk("rst_drops", rd, 32'd0);
    wb_read(9'h004, rd); chk("rst_sec", rd, 32'd0);
    wb_read(9'h11C, rd); chk("empty_window", rd, 32'hFFFF_FFFF);

    // Arm, sync on PPS, event ten cycles later sees sysclk = 9
    wb_write(9'h000, 32'h2);
    wb_read(9'h000, rd); chk("armed_ctrl", rd, 32'h0000_0006);
    pps_pulse();
    repeat (9) @(negedge clk);
    send_event(32'hCAFE_0001);
    chk("ready_after_ev", 32'(event_ready_o), 32'd1);
    exp_hdr = '{32'h5244_4531, 32'd0, 32'd0, 32'd9, 32'd0, 32'd0, 32'd0, 32'hCAFE_0001};
    check_header("sync_hdr");
    chk("ready_after_pop", 32'(event_ready_o), 32'd0);
    wb_read(9'h000, rd); chk("disarmed_ctrl", rd, 32'h0000_0004);
    wb_read(9'h104, rd); chk("empty_after_pop", rd, 32'hFFFF_FFFF);

    // Overflow: resync, six events into four slots
    wb_write(9'h000, 32'h2);
    pps_pulse();
    for (int i = 0; i < 6; i++) send_event(32'hB000_0000 + 32'(i));
    chk("ovf_full", 32'(event_full_o), 32'd1);
    wb_read(9'h000, rd); chk("ovf_ctrl", rd, 32'h0000_0408);
    wb_read(9'h010, rd); chk("ovf_drops", rd, 32'd2);
    wb_read(9'h110, rd); chk("ovf_status0", rd, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wb_read(9'h108, rd); chk($sformatf("ovf_ev%0d", i), rd, 32'(i));
      wb_read(9'h11C, rd); chk($sformatf("ovf_info%0d", i), rd, 32'hB000_0000 + 32'(i));
    end
    chk("drained_ready", 32'(event_ready_o), 32'd0);
    chk("drained_full", 32'(event_full_o), 32'd0);
    send_event(32'hB000_0006);
    wb_read(9'h108, rd); chk("gap_evcount", rd, 32'd6);
    wb_read(9'h110, rd); chk("gap_status", rd, 32'h0002_0008);
    wb_read(9'h11C, rd); chk("gap_info", rd, 32'hB000_0006);
    wb_read(9'h010, rd); chk("drops_kept", rd, 32'd2);
    wb_write(9'h010, 32'h0);
    wb_read(9'h010, rd); chk("drops_cleared", rd, 32'd0);

    // Event coincident with PPS while sec = 5
    wb_write(9'h000, 32'h2);
    pps_pulse();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pps_pulse();
    end
    @(negedge clk);
    pps = 1'b1; event_i = 1'b1; event_info = 32'hC000_0001;
    @(negedge clk);
    pps = 1'b0; event_i = 1'b0;
    wb_read(9'h004, rd); chk("pps_sec", rd, 32'd6);
    wb_read(9'h008, rd); chk("pps_last", rd, 32'd11);
    wb_read(9'h00C, rd); chk("pps_lastlast", rd, 32'd9);
    wb_read(9'h014, rd); chk("pps_sec_hi", rd, 32'd0);
    exp_hdr = '{32'h5244_4531, 32'd5, 32'd0, 32'd11, 32'd0, 32'd9, 32'd7, 32'hC000_0001};
    check_header("pps_hdr");

    // Flush with a coincident event at occupancy 3 (evcount 1..3 stored, 4 discarded)
    for (int i = 1; i <= 3; i++) send_event(32'hD000_0000 + 32'(i));
    wb_read(9'h000, rd); chk("pre_flush_ctrl", rd, 32'h0000_0300);
    event_info = 32'hD000_0004;
    wb_xfer(1'b1, 9'h000, 32'h1, 1'b1, rd);
    wb_read(9'h000, rd); chk("flush_ctrl", rd, 32'h0000_0004);
    wb_read(9'h010, rd); chk("flush_drops", rd, 32'd0);
    send_event(32'hD000_0005);
    wb_read(9'h108, rd); chk("post_flush_ev", rd, 32'd5);

    // Pop and push in the same cycle keep occupancy at one
    event_info = 32'hD000_0006;
    wb_xfer(1'b0, 9'h11C, 32'd0, 1'b1, rd); chk("popush_info", rd, 32'hD000_0005);
    wb_read(9'h000, rd); chk("popush_ctrl", rd, 32'h0000_0100);
    wb_read(9'h108, rd); chk("popush_ev", rd, 32'd6);
    wb_read(9'h11C, rd); chk("popush_info2", rd, 32'hD000_0006);

    // Push while full is rejected even when a pop happens in that cycle
    for (int i = 7; i <= 10; i++) send_event(32'hA000_0000 + 32'(i));
    event_info = 32'hA000_000B;
    wb_xfer(1'b0, 9'h11C, 32'd0, 1'b1, rd); chk("fullpop_info", rd, 32'hA000_0007);
    wb_read(9'h000, rd); chk("fullpop_ctrl", rd, 32'h0000_0300);
    wb_read(9'h010, rd); chk("fullpop_drops", rd, 32'd1);
    wb_write(9'h000, 32'h1);
    wb_read(9'h000, rd); chk("flush2_ctrl", rd, 32'h0000_0004);
    send_event(32'hA000_000C);
    wb_read(9'h108, rd); chk("flush2_ev", rd, 32'd12);
    wb_read(9'h110, rd); chk("flush2_status", rd, 32'h0001_0008);
    wb_read(9'h11C, rd); chk("flush2_info", rd, 32'hA000_000C);

    // sysclk crossing 2^32 (counter preloaded by force)
    force dut.r_sysclk = 48'h0000_FFFF_FFF0;
    send_event(32'hE000_0001);
    force dut.r_sysclk = 48'h0001_0000_0002;
    send_event(32'hE000_0002);
    release dut.r_sysclk;
    wb_read(9'h10C, rd); chk("roll_a_clk", rd, 32'hFFFF_FFF0);
    wb_read(9'h110, rd); chk("roll_a_status", rd, 32'd0);
    wb_read(9'h108, rd); chk("roll_a_ev", rd, 32'd13);
    wb_read(9'h11C, rd); chk("roll_a_info", rd, 32'hE000_0001);
    wb_read(9'h10C, rd); chk("roll_b_clk", rd, 32'h0000_0002);
    wb_read(9'h110, rd); chk("roll_b_status", rd, 32'h0000_0004);
    wb_read(9'h11C, rd); chk("roll_b_info", rd, 32'hE000_0002);

    // Reset in the middle of an access drops ack at once
    send_event(32'hF000_0001);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 9'h11C;
    @(negedge clk);
    chk("ack_before_rst", 32'(wb_ack_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("ack_on_rst", 32'(wb_ack_o), 32'd0);
    chk("ready_on_rst", 32'(event_ready_o), 32'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/radiant_event_hdr_ctrl.md
# radiant_event_hdr_ctrl

Parametrised, single-clock successor of the RADIANT event/timing control core. It keeps PPS-second, system-clock and event counters with synchronous clear on PPS. On each trigger it captures a multi-word event header into a DEPTH-deep buffer, which software drains over Wishbone. Unlike its predecessor it counts and flags dropped events, has a software flush, and supports configurable counter width and info-word count.

## Interface
Parameters:
- DEPTH, 16: header slots, power of 2, 2..64.
- NUM_INFO, 1: event info words per header, 1..8.
- CNT_WIDTH, 48: internal counter width, 33..48.

Derived: HDR_WORDS = 7 + NUM_INFO.

Ports:
- clk_i  in  1  single clock; all logic is on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone slave controls.
- wb_adr_i  in  9  byte address; bits [1:0] are ignored.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  ignored; all writes are full-word.
- wb_dat_o  out  32  read data.
- wb_ack_o, wb_err_o, wb_rty_o  out  1 each  err and rty are tied to 0.
- pps_i  in  1  one-cycle PPS pulse, already synchronous to clk_i.
- event_i  in  1  one-cycle trigger pulse.
- event_info_i  in  32*NUM_INFO  info words; word j is bits [32j+31:32j].
- event_ready_o  out  1  buffer not empty.
- event_full_o  out  1  buffer holds DEPTH headers.

## Operation
Registers:
- 0x000 CTRL
  - Write: bit0 = flush, a one-cycle pulse. bit1 = arm sync.
  - Read: bit1 armed, bit2 empty, bit3 full, bits[14:8] occupancy, others 0.
- 0x004: sec[31:0]. 0x008: last_pps_clk. 0x00C: lastlast_pps_clk.
- 0x010 DROPS: 32-bit total of dropped events, saturating. Any write clears it.
- 0x014: sec[CNT_WIDTH-1:32], zero-extended.
- Other control addresses below 0x100 read 0.

Header window at 0x100+4k:
- Read returns word k of the head header.
- k ≥ HDR_WORDS reads 0. Any read while empty returns 0xFFFFFFFF.
- Writes to the window are acked and ignored.

Header word layout:
- 0: 0x52444531 ("RDE1").
- 1: sec[31:0]. 2: evcount[31:0]. 3: sysclk[31:0].
- 4: status.
  - bit0: evcount[32] changed since the last accepted header.
  - bit1: sec[32] changed. bit2: sysclk[32] changed.
  - bit3: at least one drop since the last accepted header.
  - bits[31:16]: drops since the last accepted header, saturating at 0xFFFF.
- 5: last_pps_clk. 6: lastlast_pps_clk.
- 7+j: event_info_i word j.

Counters:
- sysclk increments every cycle.
- On pps_i: sec += 1, last_pps_clk ← sysclk[31:0], lastlast_pps_clk ← last_pps_clk.
- Sync occurs when armed && pps_i. It clears sec, sysclk, evcount, last/lastlast, the rollover reference bits and armed. The PPS increment does not apply in that cycle.
- evcount increments on every event_i, including dropped ones, so drops appear as gaps.
- All counters wrap modulo 2^CNT_WIDTH.

Capture and drop rules:
- event_i captures pre-update values from the same cycle. This holds even when it coincides with pps_i or sync.
- event_i while full: no push; DROPS and the per-header drop count increment.
- The per-header drop count clears when a header is accepted.
- Flush resets the pointers to empty. An event in the same cycle is discarded and not counted as a drop.
- Push while full is rejected even if a pop happens in the same cycle.

Reset values: counters, pointers, DROPS, armed, wb_ack_o, event_ready_o and event_full_o are all 0.

## Timing
- Ack is registered: ack ← cyc & stb & !ack; wb_ack_o = ack & cyc. Every access takes 2 cycles.
- wb_dat_o is combinational from the address and the head slot, and is stable while ack is high.
- Pop happens on the ack cycle of a read to word HDR_WORDS-1 when not empty. The head advances on the next edge.
- A pop and a push in the same cycle leave occupancy unchanged.
- After event_i at cycle n, event_ready_o is high at n+1.
- After pps_i at n, the new values at 0x004 and 0x008 are visible at n+1.
- A write that arms sync takes effect on the ack cycle; a pps_i in that same cycle does not trigger sync.
- rst_i mid-transaction drops ack immediately; the transaction is not popped.

## Test plan
- Reset, then read 0x000: returns 0x00000004 (empty); event_ready_o = 0, event_full_o = 0.
- Arm sync, pps_i at cycle 100, event_i at cycle 110 → header reads 0x52444531, sec = 0, evcount = 0, sysclk = 9.
- With DEPTH = 4, send 6 events → full = 1 and DROPS = 2. Drain 4 headers, send 1 more → status bit3 = 1, bits[31:16] = 2, evcount = 6.
- event_i coincident with pps_i with sec = 5 → header sec = 5; 0x004 reads 6.
- Flush coincident with event_i while occupancy = 3 → empty, DROPS unchanged, the next event gets evcount + 1.
- Preload sysclk = 0xFFFFFFF0, event before and after the 2^32 crossing → second header status bit2 = 1, sysclk[31:0] is small.
